ip_packet_rx: RTL and testbench

IP_PACKET_RX -- requirements
Module: ip_packet_rx

---
 rtl/ip_packet_rx_pkg.sv | 18 +
 rtl/ip_packet_rx.sv | 151 +++++++++++++++
 tb/tb_ip_packet_rx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ip_packet_rx_pkg.sv
// Shared sizes and FSM state encoding for the IPv4/Ethernet frame receiver.
package ip_packet_rx_pkg;

   localparam int unsigned ETH_HDR_SIZE_BYTES = 14;
   localparam int unsigned IP_HDR_SIZE_BYTES  = 20;
   localparam int unsigned IP_ADDR_WIDTH      = 32;
   localparam int unsigned MAC_ADDR_WIDTH     = 48;
   localparam int unsigned COUNTER_WIDTH      = 16;
   localparam int unsigned HDR_SIZE_BYTES     = ETH_HDR_SIZE_BYTES + IP_HDR_SIZE_BYTES;

   typedef enum logic [1:0] {
      ETH_HDR,
      IP_HDR,
      PAYLOAD,
      DROP
   } rx_state_t;

endpackage

// File: rtl/ip_packet_rx.sv
// Receives Ethernet/IPv4 frames byte-wise from a MAC stream, filters on own MAC/IP
// address and exact payload length, and captures source addresses and payload.
module ip_packet_rx
   import ip_packet_rx_pkg::*;
#(
   parameter int unsigned USER_DATA_BYTES = 785
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [IP_ADDR_WIDTH-1:0]      ACCELERATOR_IP_ADDRESS,
   input  logic [MAC_ADDR_WIDTH-1:0]     ACCELERATOR_MAC_ADDRESS,
   input  logic [7:0]                    MAC_DATA_OUT,
   output logic                          MAC_DATA_READY,
   input  logic                          MAC_DATA_VALID,
   input  logic                          MAC_DATA_LAST,
   input  logic                          MAC_DATA_TUSER,
   output logic [USER_DATA_BYTES*8-1:0]  DATA_FRAME,
   output logic [IP_ADDR_WIDTH-1:0]      SRC_IP_ADDRESS,
   output logic [MAC_ADDR_WIDTH-1:0]     SRC_MAC_ADDRESS,
   output logic                          FRAME_READY,
   output logic                          PACKET_FOR_ACCELERATOR
);

   localparam int unsigned FRAME_BITS  = USER_DATA_BYTES * 8;
   localparam int unsigned FRAME_IDX_W = $clog2(FRAME_BITS);

   typedef logic [COUNTER_WIDTH-1:0] cnt_t;

   localparam cnt_t DST_MAC_LAST  = COUNTER_WIDTH'(5);
   localparam cnt_t SRC_MAC_FIRST = COUNTER_WIDTH'(6);
   localparam cnt_t SRC_MAC_LAST  = COUNTER_WIDTH'(11);
   localparam cnt_t ETH_LAST      = COUNTER_WIDTH'(ETH_HDR_SIZE_BYTES - 1);
   localparam cnt_t SRC_IP_FIRST  = COUNTER_WIDTH'(ETH_HDR_SIZE_BYTES + 12);
   localparam cnt_t DST_IP_FIRST  = COUNTER_WIDTH'(ETH_HDR_SIZE_BYTES + 16);
   localparam cnt_t IP_LAST       = COUNTER_WIDTH'(HDR_SIZE_BYTES - 1);
   localparam cnt_t PAYLOAD_FIRST = COUNTER_WIDTH'(HDR_SIZE_BYTES);
   localparam cnt_t FRAME_LAST    = COUNTER_WIDTH'(HDR_SIZE_BYTES + USER_DATA_BYTES - 1);

   rx_state_t                   state_q, state_d;
   cnt_t                        count_q;
   logic                        ready_q;
   logic                        frame_ready_q;
   logic                        for_acc_q;
   logic [MAC_ADDR_WIDTH-1:0]   dst_mac_q;
   logic [IP_ADDR_WIDTH-1:0]    dst_ip_q;
   logic [MAC_ADDR_WIDTH-1:0]   src_mac_q;
   logic [IP_ADDR_WIDTH-1:0]    src_ip_q;
   logic [FRAME_BITS-1:0]       data_q;

   logic                        beat_c;
   logic                        good_c;
   logic                        match_c;
   logic [MAC_ADDR_WIDTH-1:0]   dst_mac_c;
   logic [IP_ADDR_WIDTH-1:0]    dst_ip_c;
   logic [2:0]                  smac_idx_c;
   logic [1:0]                  sip_idx_c;
   cnt_t                        pay_idx_c;
   logic [FRAME_IDX_W-1:0]      bit_idx_c;

   assign beat_c     = MAC_DATA_VALID & ready_q;
   // Destination fields including the byte on the bus, for same-beat comparison
   assign dst_mac_c  = {MAC_DATA_OUT, dst_mac_q[MAC_ADDR_WIDTH-1:8]};
   assign dst_ip_c   = {MAC_DATA_OUT, dst_ip_q[IP_ADDR_WIDTH-1:8]};
   assign smac_idx_c = 3'(count_q - SRC_MAC_FIRST);
   assign sip_idx_c  = 2'(count_q - SRC_IP_FIRST);
   assign pay_idx_c  = count_q - PAYLOAD_FIRST;
   assign bit_idx_c  = FRAME_IDX_W'({pay_idx_c, 3'b000});

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= ETH_HDR;
      else        state_q <= state_d;
   end

   // Next state; any accepted LAST returns to header parsing for the next frame
   always_comb begin
      state_d = state_q;
      good_c  = 1'b0;
      match_c = 1'b0;
      if (beat_c) begin
         unique case (state_q)
            ETH_HDR: begin
               if (count_q == DST_MAC_LAST && dst_mac_c != ACCELERATOR_MAC_ADDRESS)
                  state_d = DROP;
               else if (count_q == ETH_LAST)
                  state_d = IP_HDR;
            end
            IP_HDR: begin
               if (count_q == IP_LAST) begin
                  match_c = (dst_ip_c == ACCELERATOR_IP_ADDRESS);
                  state_d = match_c ? PAYLOAD : DROP;
               end
            end
            PAYLOAD: begin
               if (count_q == FRAME_LAST) begin
                  state_d = DROP;
                  good_c  = MAC_DATA_LAST & ~MAC_DATA_TUSER;
               end
            end
            DROP: state_d = DROP;
         endcase
         if (MAC_DATA_LAST) state_d = ETH_HDR;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         count_q       <= '0;
         ready_q       <= 1'b0;
         frame_ready_q <= 1'b0;
         for_acc_q     <= 1'b0;
         dst_mac_q     <= '0;
         dst_ip_q      <= '0;
         src_mac_q     <= '0;
         src_ip_q      <= '0;
         data_q        <= '0;
      end else begin
         ready_q       <= 1'b1;
         frame_ready_q <= good_c;
         if (beat_c) begin
            count_q <= MAC_DATA_LAST ? '0 : count_q + COUNTER_WIDTH'(1);
            unique case (state_q)
               ETH_HDR: begin
                  if (count_q == '0) for_acc_q <= 1'b0;
                  if (count_q <= DST_MAC_LAST)
                     dst_mac_q <= dst_mac_c;
                  else if (count_q <= SRC_MAC_LAST)
                     src_mac_q[{smac_idx_c, 3'b000} +: 8] <= MAC_DATA_OUT;
               end
               IP_HDR: begin
                  if (count_q >= SRC_IP_FIRST && count_q < DST_IP_FIRST)
                     src_ip_q[{sip_idx_c, 3'b000} +: 8] <= MAC_DATA_OUT;
                  else if (count_q >= DST_IP_FIRST)
                     dst_ip_q <= dst_ip_c;
                  // MAC already matched, otherwise the frame would be in DROP
                  if (match_c) for_acc_q <= 1'b1;
               end
               PAYLOAD: data_q[bit_idx_c +: 8] <= MAC_DATA_OUT;
               DROP: ;
            endcase
         end
      end
   end

   assign MAC_DATA_READY         = ready_q;
   assign FRAME_READY            = frame_ready_q;
   assign PACKET_FOR_ACCELERATOR = for_acc_q;
   assign SRC_MAC_ADDRESS        = src_mac_q;
   assign SRC_IP_ADDRESS         = src_ip_q;
   assign DATA_FRAME             = data_q;

endmodule

// File: tb/tb_ip_packet_rx.sv
// Directed self-checking bench for ip_packet_rx: good, size-error, FCS-error,
// address-mismatch, early-LAST and mid-frame-reset frames.
module tb_ip_packet_rx;

   localparam int unsigned UDB = 785;
   localparam logic [111:0] ETH_OK  = 112'h9999ddddddddddddccffffffffff;
   localparam logic [111:0] ETH_ALT = 112'h9999a1b2c3d4e5f6ccffffffffff;
   localparam logic [111:0] ETH_BAD = 112'h9999dddddddddddd112233445566;
   localparam logic [159:0] IP_OK   = 160'hbbaaaaaacccccccc999999999999999999999999;
   localparam logic [159:0] IP_ALT  = 160'hbbaaaaaa12345678999999999999999999999999;
   localparam logic [159:0] IP_BAD  = 160'heeeeeeeecccccccc999999999999999999999999;

   logic                 ACLK;
   logic                 ARESET;
   logic [31:0]          ACCELERATOR_IP_ADDRESS;
   logic [47:0]          ACCELERATOR_MAC_ADDRESS;
   logic [7:0]           MAC_DATA_OUT;
   logic                 MAC_DATA_READY;
   logic                 MAC_DATA_VALID;
   logic                 MAC_DATA_LAST;
   logic                 MAC_DATA_TUSER;
   logic [UDB*8-1:0]     DATA_FRAME;
   logic [31:0]          SRC_IP_ADDRESS;
   logic [47:0]          SRC_MAC_ADDRESS;
   logic                 FRAME_READY;
   logic                 PACKET_FOR_ACCELERATOR;

   int n_total = 0;
   int n_bad   = 0;
   int pulse_cnt = 0;

   ip_packet_rx #(.USER_DATA_BYTES(UDB)) dut (
      .ACLK                    (ACLK),
      .ARESET                  (ARESET),
      .ACCELERATOR_IP_ADDRESS  (ACCELERATOR_IP_ADDRESS),
      .ACCELERATOR_MAC_ADDRESS (ACCELERATOR_MAC_ADDRESS),
      .MAC_DATA_OUT            (MAC_DATA_OUT),
      .MAC_DATA_READY          (MAC_DATA_READY),
      .MAC_DATA_VALID          (MAC_DATA_VALID),
      .MAC_DATA_LAST           (MAC_DATA_LAST),
      .MAC_DATA_TUSER          (MAC_DATA_TUSER),
      .DATA_FRAME              (DATA_FRAME),
      .SRC_IP_ADDRESS          (SRC_IP_ADDRESS),
      .SRC_MAC_ADDRESS         (SRC_MAC_ADDRESS),
      .FRAME_READY             (FRAME_READY),
      .PACKET_FOR_ACCELERATOR  (PACKET_FOR_ACCELERATOR)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Counts cycles in which FRAME_READY was high
   always @(posedge ACLK) if (FRAME_READY) pulse_cnt <= pulse_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_data(input string tag, input logic pat, input logic [7:0] pb);
      int errs;
      int first;
      logic [7:0] exp_b;
      logic [7:0] obs_b;
      errs = 0;
      first = -1;
      for (int j = 0; j < int'(UDB); j++) begin
         exp_b = pat ? (8'(j) ^ 8'h5a) : pb;
         obs_b = DATA_FRAME[j*8 +: 8];
         if (obs_b !== exp_b) begin
            if (first < 0) first = j;
            errs++;
         end
      end
      n_total++;
      assert (errs === 0) else begin
         n_bad++;
         $error("FAIL %s: observed=%0d bad payload bytes (first at %0d) expected=0", tag, errs, first);
      end
   endtask

   task automatic send_frame(input int n, input logic hdr, input logic [111:0] eth,
                             input logic [159:0] ip, input logic pat, input logic [7:0] pb,
                             input logic tuser, input logic do_last,
                             output logic fr_next, output int pulses);
      int p0;
      int waits;
      logic [7:0] b;
      waits = 0;
      while (MAC_DATA_READY !== 1'b1 && waits < 20) begin
         @(negedge ACLK);
         waits++;
      end
      chk("ready_wait", 64'(MAC_DATA_READY), 64'd1);
      p0 = pulse_cnt;
      for (int i = 0; i < n; i++) begin
         @(negedge ACLK);
         if (!hdr)        b = pb;
         else if (i < 14) b = eth[i*8 +: 8];
         else if (i < 34) b = ip[(i-14)*8 +: 8];
         else if (pat)    b = 8'(i - 34) ^ 8'h5a;
         else             b = pb;
         MAC_DATA_OUT   = b;
         MAC_DATA_VALID = 1'b1;
         MAC_DATA_LAST  = do_last && (i == n - 1);
         MAC_DATA_TUSER = do_last && (i == n - 1) && tuser;
      end
      @(negedge ACLK);
      MAC_DATA_VALID = 1'b0;
      MAC_DATA_LAST  = 1'b0;
      MAC_DATA_TUSER = 1'b0;
      fr_next = FRAME_READY;
      @(negedge ACLK);
      pulses = pulse_cnt - p0;
   endtask

   task automatic run_good(input string tag, input logic [111:0] eth, input logic [159:0] ip,
                           input logic pat, input logic [7:0] pb,
                           input logic [47:0] exp_mac, input logic [31:0] exp_ip);
      logic fr;
      int   np;
      send_frame(34 + int'(UDB), 1'b1, eth, ip, pat, pb, 1'b0, 1'b1, fr, np);
      chk({tag, "_ready_next"}, 64'(fr), 64'd1);
      chk({tag, "_pulses"}, 64'(np), 64'd1);
      chk({tag, "_src_mac"}, 64'(SRC_MAC_ADDRESS), 64'(exp_mac));
      chk({tag, "_src_ip"}, 64'(SRC_IP_ADDRESS), 64'(exp_ip));
      chk({tag, "_for_acc"}, 64'(PACKET_FOR_ACCELERATOR), 64'd1);
      chk_data({tag, "_data"}, pat, pb);
   endtask

   task automatic run_bad(input string tag, input int n, input logic hdr, input logic [111:0] eth,
                          input logic [159:0] ip, input logic [7:0] pb, input logic tuser,
                          input logic exp_acc);
      logic fr;
      int   np;
      send_frame(n, hdr, eth, ip, 1'b0, pb, tuser, 1'b1, fr, np);
      chk({tag, "_ready_next"}, 64'(fr), 64'd0);
      chk({tag, "_pulses"}, 64'(np), 64'd0);
      chk({tag, "_for_acc"}, 64'(PACKET_FOR_ACCELERATOR), 64'(exp_acc));
   endtask

   initial begin
      logic fr;
      int   np;
      int   bad_len [4];
      bad_len = '{765, 784, 786, 805};

      ARESET                  = 1'b1;
      ACCELERATOR_IP_ADDRESS  = 32'hbbaaaaaa;
      ACCELERATOR_MAC_ADDRESS = 48'hccffffffffff;
      MAC_DATA_OUT            = 8'h00;
      MAC_DATA_VALID          = 1'b0;
      MAC_DATA_LAST           = 1'b0;
      MAC_DATA_TUSER          = 1'b0;
      repeat (3) @(negedge ACLK);

      chk("rst_ready", 64'(MAC_DATA_READY), 64'd0);
      chk("rst_frame_ready", 64'(FRAME_READY), 64'd0);
      chk("rst_for_acc", 64'(PACKET_FOR_ACCELERATOR), 64'd0);
      chk("rst_src_mac", 64'(SRC_MAC_ADDRESS), 64'd0);
      chk("rst_src_ip", 64'(SRC_IP_ADDRESS), 64'd0);
      chk_data("rst_data", 1'b0, 8'h00);

      ARESET = 1'b0;
      @(negedge ACLK);
      @(negedge ACLK);
      chk("ready_after_rst", 64'(MAC_DATA_READY), 64'd1);

      run_good("good1", ETH_OK, IP_OK, 1'b0, 8'h01, 48'hdddddddddddd, 32'hcccccccc);

      for (int k = 0; k < 4; k++) begin
         run_bad($sformatf("size%0d", bad_len[k]), 34 + bad_len[k], 1'b1, ETH_OK, IP_OK,
                 8'h01, 1'b0, 1'b1);
         run_good($sformatf("after_size%0d", bad_len[k]), ETH_OK, IP_OK, k[0], 8'h01,
                  48'hdddddddddddd, 32'hcccccccc);
      end

      run_bad("tuser", 34 + int'(UDB), 1'b1, ETH_OK, IP_OK, 8'h01, 1'b1, 1'b1);
      run_good("after_tuser", ETH_OK, IP_OK, 1'b0, 8'h01, 48'hdddddddddddd, 32'hcccccccc);

      run_bad("dst_ip", 34 + int'(UDB), 1'b1, ETH_OK, IP_BAD, 8'h01, 1'b0, 1'b0);
      run_good("after_dst_ip", ETH_OK, IP_OK, 1'b1, 8'h00, 48'hdddddddddddd, 32'hcccccccc);

      run_bad("dst_mac", 34 + int'(UDB), 1'b1, ETH_BAD, IP_OK, 8'h01, 1'b0, 1'b0);
      run_good("after_dst_mac", ETH_ALT, IP_ALT, 1'b1, 8'h00, 48'ha1b2c3d4e5f6, 32'h12345678);

      run_bad("early13", 13, 1'b0, ETH_OK, IP_OK, 8'hff, 1'b0, 1'b0);
      run_good("after_early13", ETH_OK, IP_OK, 1'b0, 8'h01, 48'hdddddddddddd, 32'hcccccccc);
      run_bad("early37", 37, 1'b0, ETH_OK, IP_OK, 8'hff, 1'b0, 1'b0);
      run_good("after_early37", ETH_OK, IP_OK, 1'b0, 8'h01, 48'hdddddddddddd, 32'hcccccccc);

      // Reset in the middle of a frame whose headers already matched
      send_frame(40, 1'b1, ETH_ALT, IP_ALT, 1'b0, 8'h01, 1'b0, 1'b0, fr, np);
      chk("partial_pulses", 64'(np), 64'd0);
      chk("partial_for_acc", 64'(PACKET_FOR_ACCELERATOR), 64'd1);
      ARESET = 1'b1;
      @(negedge ACLK);
      chk("midrst_for_acc", 64'(PACKET_FOR_ACCELERATOR), 64'd0);
      chk("midrst_src_mac", 64'(SRC_MAC_ADDRESS), 64'd0);
      chk("midrst_ready", 64'(MAC_DATA_READY), 64'd0);
      chk_data("midrst_data", 1'b0, 8'h00);
      ARESET = 1'b0;
      run_good("after_midrst", ETH_OK, IP_OK, 1'b1, 8'h00, 48'hdddddddddddd, 32'hcccccccc);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
